// File: rtl/maxterm_sweep_ctrl_if.sv
// maxterm_sweep_ctrl_if: control, evaluator and result signals of the maxterm sweep sequencer
interface maxterm_sweep_ctrl_if;
  logic        start;
  logic        abort;
  logic [15:0] cfg_mask;
  logic        f_in;
  logic [3:0]  abcd;
  logic        busy;
  logic        done;
  logic [15:0] truth_table;
  logic [4:0]  mismatch_cnt;
  logic [3:0]  first_fail;
  logic        first_fail_vld;
  modport master (
    output start, abort, cfg_mask, f_in,
    input  abcd, busy, done, truth_table, mismatch_cnt, first_fail, first_fail_vld
  );
  modport slave (
    input  start, abort, cfg_mask, f_in,
    output abcd, busy, done, truth_table, mismatch_cnt, first_fail, first_fail_vld
  );
endinterface

// File: rtl/maxterm_sweep_ctrl.sv
// maxterm_sweep_ctrl: sweeps all 16 abcd vectors through a maxterm evaluator and self-checks against a mask
module maxterm_sweep_ctrl #(
  parameter int SETTLE = 1
) (
  input logic clk,
  input logic rst_n,
  maxterm_sweep_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;
  state_t state, state_nxt;
  logic [15:0] mask;
  logic [3:0] wcnt;
  logic accept;
  assign accept = state == IDLE && bus.start && !bus.abort;
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // next state: abort wins everywhere outside IDLE, and over start inside IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = accept ? WAIT : IDLE;
      WAIT:    state_nxt = bus.abort ? IDLE : (wcnt == 4'(SETTLE - 1) ? SAMPLE : WAIT);
      SAMPLE:  state_nxt = bus.abort ? IDLE : (bus.abcd == 4'd15 ? DONE : WAIT);
      default: state_nxt = IDLE;
    endcase
  end
  // vector stepping, settle counting and result capture; a sample in SAMPLE commits even on abort
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mask <= '0;
      wcnt <= '0;
      bus.abcd <= '0;
      bus.truth_table <= '0;
      bus.mismatch_cnt <= '0;
      bus.first_fail <= '0;
      bus.first_fail_vld <= 1'b0;
    end else begin
      if (accept) begin
        mask <= bus.cfg_mask;
        wcnt <= '0;
        bus.abcd <= '0;
        bus.truth_table <= '0;
        bus.mismatch_cnt <= '0;
        bus.first_fail_vld <= 1'b0;
      end
      if (state == WAIT) wcnt <= wcnt + 4'd1;
      if (state == SAMPLE) begin
        bus.truth_table[bus.abcd] <= bus.f_in;
        if (bus.f_in == mask[bus.abcd]) begin
          bus.mismatch_cnt <= bus.mismatch_cnt + 5'd1;
          if (!bus.first_fail_vld) begin
            bus.first_fail <= bus.abcd;
            bus.first_fail_vld <= 1'b1;
          end
        end
        if (bus.abcd != 4'd15 && !bus.abort) begin
          bus.abcd <= bus.abcd + 4'd1;
          wcnt <= '0;
        end
      end
    end
endmodule

// File: tb/tb_maxterm_sweep_ctrl.sv
// tb_maxterm_sweep_ctrl: directed table-driven checks of the maxterm sweep sequencer at SETTLE=1 and SETTLE=3
module tb_maxterm_sweep_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic start, abort, sel;
  logic [1:0] mode;
  logic [15:0] cfg_mask;
  int checks = 0;
  int errors = 0;
  maxterm_sweep_ctrl_if b1 ();
  maxterm_sweep_ctrl_if b3 ();
  maxterm_sweep_ctrl #(.SETTLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  maxterm_sweep_ctrl #(.SETTLE(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));
  always #5 clk = ~clk;
  function automatic logic ref_f(input logic [3:0] v);
    logic a, b, c, d;
    {a, b, c, d} = v;
    return (c | d) & (b | c | ~a) & (~b | ~c | ~d) & (b | ~c | d);
  endfunction
  assign b1.start = start & ~sel;
  assign b3.start = start & sel;
  assign b1.abort = abort;
  assign b3.abort = abort;
  assign b1.cfg_mask = cfg_mask;
  assign b3.cfg_mask = cfg_mask;
  assign b1.f_in = mode == 2'd0 ? ref_f(b1.abcd) : mode == 2'd1;
  assign b3.f_in = mode == 2'd0 ? ref_f(b3.abcd) : mode == 2'd1;
  logic [3:0] abcd, first_fail;
  logic busy, done, first_fail_vld;
  logic [15:0] truth_table;
  logic [4:0] mismatch_cnt;
  logic [31:0] all1;
  assign abcd = sel ? b3.abcd : b1.abcd;
  assign busy = sel ? b3.busy : b1.busy;
  assign done = sel ? b3.done : b1.done;
  assign truth_table = sel ? b3.truth_table : b1.truth_table;
  assign mismatch_cnt = sel ? b3.mismatch_cnt : b1.mismatch_cnt;
  assign first_fail = sel ? b3.first_fail : b1.first_fail;
  assign first_fail_vld = sel ? b3.first_fail_vld : b1.first_fail_vld;
  assign all1 = {b1.abcd, b1.busy, b1.done, b1.truth_table, b1.mismatch_cnt, b1.first_fail, b1.first_fail_vld};
  typedef struct {
    logic        sel;
    logic [1:0]  mode;
    logic [15:0] mask;
    logic [15:0] tt;
    logic [4:0]  cnt;
    logic [3:0]  ff;
    logic        ffv;
  } vec_t;
  vec_t vecs [6];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask
  task automatic sweep(input vec_t v, input bit pulse_mid);
    int n, per, bad;
    sel = v.sel;
    mode = v.mode;
    cfg_mask = v.mask;
    per = v.sel ? 4 : 2;
    bad = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cfg_mask = ~v.mask;
    n = 1;
    while (!done && n < 200) begin
      if (abcd != 4'((n - 1) / per)) bad++;
      start = pulse_mid && n == 10;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("abcd_seq", bad, 0);
    chk("done_cycle", n, 16 * per + 1);
    chk("truth_table", truth_table, v.tt);
    chk("mismatch_cnt", mismatch_cnt, v.cnt);
    chk("first_fail_vld", first_fail_vld, v.ffv);
    if (v.ffv) chk("first_fail", first_fail, v.ff);
    @(negedge clk);
    chk("done_one_cycle", {busy, done}, 0);
  endtask
  initial begin
    int n, seen;
    vecs[0] = '{1'b0, 2'd0, 16'h9795, 16'h686A, 5'd0,  4'd0, 1'b0};
    vecs[1] = '{1'b0, 2'd0, 16'h9797, 16'h686A, 5'd1,  4'd1, 1'b1};
    vecs[2] = '{1'b1, 2'd1, 16'h0000, 16'hFFFF, 5'd0,  4'd0, 1'b0};
    vecs[3] = '{1'b0, 2'd1, 16'hFFFF, 16'hFFFF, 5'd16, 4'd0, 1'b1};
    vecs[4] = '{1'b0, 2'd0, 16'h0000, 16'h686A, 5'd9,  4'd0, 1'b1};
    vecs[5] = '{1'b1, 2'd2, 16'hFFFF, 16'h0000, 5'd0,  4'd0, 1'b0};
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    sel = 1'b0;
    mode = 2'd0;
    cfg_mask = '0;
    #1;
    chk("reset_outputs", all1, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) sweep(vecs[i], 1'b0);
    sel = 1'b0;
    mode = 2'd0;
    cfg_mask = 16'h9795;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (n = 0; n < 100 && abcd != 4'd5; n++) @(negedge clk);
    chk("abort_reach", abcd, 5);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_tt", truth_table, 16'h000A);
    chk("abort_abcd", abcd, 5);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    chk("abort_no_done", seen, 0);
    sweep(vecs[0], 1'b1);
    sel = 1'b0;
    cfg_mask = 16'h0000;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", all1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    chk("start_abort_idle", busy, 0);
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk("start_abort_stays", {busy, done}, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
